// File: rtl/approx_mult_error_monitor_pkg.sv
// Shared definitions for the approximate-multiplier error monitor family:
// default operand width, window FSM encoding and accumulator guard width.
package approx_pkg;

  localparam int WIDTH_DEF = 16;

  // One carry bit above the accumulator detects overflow for saturation
  localparam int SAT_GUARD = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/approx_mult_error_monitor_abs_err_stage.sv
// Registered error stage: exact unsigned product of the operands and the
// absolute difference to the approximate product, with operands forwarded.
module abs_err_stage
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [2*WIDTH-1:0]   approx_in,
  output logic                 v_q,
  output logic [WIDTH-1:0]     a_q,
  output logic [WIDTH-1:0]     b_q,
  output logic [2*WIDTH-1:0]   abs_err_q
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]        exact_s;
  logic signed [PW:0]   diff_s;
  logic                 v_d;
  logic [WIDTH-1:0]     a_d;
  logic [WIDTH-1:0]     b_d;
  logic [PW-1:0]        abs_err_d;

  // Exact product and absolute error of the incoming sample
  always_comb begin
    exact_s = PW'(a_in) * PW'(b_in);
    diff_s  = $signed({1'b0, exact_s}) - $signed({1'b0, approx_in});
    // magnitude of a (PW+1)-bit difference always fits in PW bits
    abs_err_d = PW'(diff_s[PW] ? -diff_s : diff_s);
    v_d = v_in;
    a_d = a_in;
    b_d = b_in;
  end

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= 1'b0;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      abs_err_q <= {PW{1'b0}};
    end else begin
      v_q       <= v_d;
      a_q       <= a_d;
      b_q       <= b_d;
      abs_err_q <= abs_err_d;
    end
  end

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Windowed error-statistics monitor for an approximate multiplier: samples
// operands and product, and accumulates error count, sum, maximum and argmax.
module approx_mult_error_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 11,
  parameter int SUM_W  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [2*WIDTH-1:0]   approx_out,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [SUM_W-1:0]     sum_abs_err,
  output logic [2*WIDTH-1:0]   max_abs_err,
  output logic [WIDTH-1:0]     max_in1,
  output logic [WIDTH-1:0]     max_in2
);

  localparam int PW = 2 * WIDTH;
  localparam int PAD_W = SUM_W + SAT_GUARD - PW;
  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1'b1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [PW-1:0] p1_q, p1_d;
  logic v2_q;
  logic [WIDTH-1:0] a2_q, b2_q;
  logic [PW-1:0] err2_q;
  logic [CNT_W-1:0] sample_count_q, sample_count_d, err_count_q, err_count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W+SAT_GUARD-1:0] sum_ext_s;
  logic [PW-1:0] max_q, max_d;
  logic [WIDTH-1:0] max_in1_q, max_in1_d, max_in2_q, max_in2_d;
  logic busy_q, busy_d, done_q, done_d;
  logic ready_s, accept_s;

  assign ready_s  = (state_q == RUN) && (acc_q < WINDOW_C);
  assign accept_s = valid_in && ready_s;

  abs_err_stage #(.WIDTH(WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .v_in      (v1_q),
    .a_in      (a1_q),
    .b_in      (b1_q),
    .approx_in (p1_q),
    .v_q       (v2_q),
    .a_q       (a2_q),
    .b_q       (b2_q),
    .abs_err_q (err2_q)
  );

  // Next-state: capture stage, window FSM and statistics accumulation
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_d          = sum_q;
    max_d          = max_q;
    max_in1_d      = max_in1_q;
    max_in2_d      = max_in2_q;
    sum_ext_s      = {{PAD_W{1'b0}}, err2_q} + {{SAT_GUARD{1'b0}}, sum_q};

    v1_d = accept_s;
    if (accept_s) begin
      a1_d = in1;
      b1_d = in2;
      p1_d = approx_out;
    end else begin
      a1_d = a1_q;
      b1_d = b1_q;
      p1_d = p1_q;
    end

    if (v2_q) begin
      sample_count_d = sample_count_q + ONE_C;
      err_count_d    = err_count_q + {{(CNT_W-1){1'b0}}, (err2_q != {PW{1'b0}})};
      sum_d = sum_ext_s[SUM_W] ? {SUM_W{1'b1}} : sum_ext_s[SUM_W-1:0];
      // strict compare keeps the earliest sample on ties
      if (err2_q > max_q) begin
        max_d     = err2_q;
        max_in1_d = a2_q;
        max_in2_d = b2_q;
      end else begin
        max_d     = max_q;
      end
    end else begin
      sum_d = sum_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = RUN;
          acc_d          = {CNT_W{1'b0}};
          sample_count_d = {CNT_W{1'b0}};
          err_count_d    = {CNT_W{1'b0}};
          sum_d          = {SUM_W{1'b0}};
          max_d          = {PW{1'b0}};
          max_in1_d      = {WIDTH{1'b0}};
          max_in2_d      = {WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          acc_d   = acc_q + ONE_C;
          state_d = (acc_d == WINDOW_C) ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!v1_q && !v2_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= {CNT_W{1'b0}};
      v1_q           <= 1'b0;
      a1_q           <= {WIDTH{1'b0}};
      b1_q           <= {WIDTH{1'b0}};
      p1_q           <= {PW{1'b0}};
      sample_count_q <= {CNT_W{1'b0}};
      err_count_q    <= {CNT_W{1'b0}};
      sum_q          <= {SUM_W{1'b0}};
      max_q          <= {PW{1'b0}};
      max_in1_q      <= {WIDTH{1'b0}};
      max_in2_q      <= {WIDTH{1'b0}};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      v1_q           <= v1_d;
      a1_q           <= a1_d;
      b1_q           <= b1_d;
      p1_q           <= p1_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_q          <= sum_d;
      max_q          <= max_d;
      max_in1_q      <= max_in1_d;
      max_in2_q      <= max_in2_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign ready        = ready_s;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;
  assign max_in1      = max_in1_q;
  assign max_in2      = max_in2_q;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor: WINDOW=4, SUM_W=33 so that
// saturation is reachable with 16-bit operands.
module tb_approx_mult_error_monitor;

  localparam int W = 16;
  localparam int CW = 11;
  localparam int SW = 33;

  logic clk = 1'b0;
  logic rst, start, valid_in;
  logic [W-1:0] in1, in2;
  logic [2*W-1:0] approx_out;
  logic ready, busy, done;
  logic [CW-1:0] sample_count, err_count;
  logic [SW-1:0] sum_abs_err;
  logic [2*W-1:0] max_abs_err;
  logic [W-1:0] max_in1, max_in2;

  int total = 0;
  int bad = 0;
  logic [W-1:0] va[6];
  logic [W-1:0] vb[6];
  logic [2*W-1:0] vp[6];

  approx_mult_error_monitor #(.WIDTH(W), .WINDOW(4), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
    .in1(in1), .in2(in2), .approx_out(approx_out),
    .ready(ready), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
    .max_in1(max_in1), .max_in2(max_in2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input logic [63:0] sc, input logic [63:0] ec,
                             input logic [63:0] sm, input logic [63:0] mx,
                             input logic [63:0] m1, input logic [63:0] m2);
    check_eq({tag, "_count"}, sample_count, sc);
    check_eq({tag, "_err"},   err_count, ec);
    check_eq({tag, "_sum"},   sum_abs_err, sm);
    check_eq({tag, "_max"},   max_abs_err, mx);
    check_eq({tag, "_in1"},   max_in1, m1);
    check_eq({tag, "_in2"},   max_in2, m2);
  endtask

  // start, four back-to-back samples from va/vb/vp, then wait for done
  task automatic run_window(input string tag);
    int k;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy"}, busy, 64'd1);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; in1 = va[i]; in2 = vb[i]; approx_out = vp[i];
      tick();
    end
    valid_in = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check_eq({tag, "_lat"}, k, 64'd3);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input logic [31:0] p);
    va[i] = W'(a);
    vb[i] = W'(b);
    vp[i] = p;
  endtask

  initial begin
    int k;
    int seen;
    rst = 1'b1; start = 1'b0; valid_in = 1'b0;
    in1 = '0; in2 = '0; approx_out = '0;
    tick();
    tick();
    check_stats("rst", 0, 0, 0, 0, 0, 0);
    check_eq("rst_busy", busy, 64'd0);
    check_eq("rst_done", done, 64'd0);
    check_eq("rst_ready", ready, 64'd0);
    rst = 1'b0;
    tick();

    // exact products: no error, done 3 edges after last accept, pulse and hold
    set_vec(0, 3, 5, 15); set_vec(1, 7, 11, 77);
    set_vec(2, 100, 200, 20000); set_vec(3, 65535, 2, 131070);
    run_window("exact");
    check_stats("exact", 4, 0, 0, 0, 0, 0);
    tick();
    check_eq("exact_pulse", done, 64'd0);
    check_eq("exact_idle", busy, 64'd0);
    tick(); tick();
    check_eq("exact_hold", sample_count, 64'd4);

    // underestimates 4 and 1, then two exact samples
    set_vec(0, 782, 767, 599790); set_vec(1, 100, 100, 9999);
    set_vec(2, 1, 1, 1); set_vec(3, 0, 0, 0);
    run_window("under");
    check_stats("under", 4, 2, 5, 4, 782, 767);
    tick();

    // overestimates tie at 3: earliest operands kept
    set_vec(0, 3, 3, 12); set_vec(1, 2, 2, 7);
    set_vec(2, 5, 5, 25); set_vec(3, 0, 9, 0);
    run_window("tie");
    check_stats("tie", 4, 2, 6, 3, 3, 3);
    tick();

    // 65535^2 with approx 0: third sample overflows 33-bit sum
    for (int i = 0; i < 4; i++) set_vec(i, 65535, 65535, 0);
    run_window("sat");
    check_stats("sat", 4, 4, 64'h1_FFFF_FFFF, 64'hFFFE_0001, 65535, 65535);
    tick();

    // valid held 6 cycles, start pulsed during RUN
    set_vec(0, 1, 2, 2); set_vec(1, 3, 4, 12); set_vec(2, 5, 6, 30);
    set_vec(3, 7, 8, 50); set_vec(4, 10, 10, 0); set_vec(5, 20, 20, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("hold_ready_on", ready, 64'd1);
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; in1 = va[i]; in2 = vb[i]; approx_out = vp[i];
      start = (i == 1) ? 1'b1 : 1'b0;
      tick();
      if (i == 3) check_eq("hold_ready_off", ready, 64'd0);
    end
    valid_in = 1'b0; start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check_eq("hold_lat", k, 64'd1);
    check_stats("hold", 4, 1, 6, 6, 7, 8);
    tick();

    // reset mid-window after two accepts
    set_vec(0, 10, 10, 90); set_vec(1, 4, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; in1 = va[i]; in2 = vb[i]; approx_out = vp[i];
      tick();
    end
    valid_in = 1'b0;
    tick(); tick();
    check_eq("abort_pre", sample_count, 64'd2);
    rst = 1'b1;
    #1;
    check_stats("abort", 0, 0, 0, 0, 0, 0);
    check_eq("abort_busy", busy, 64'd0);
    check_eq("abort_ready", ready, 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check_eq("abort_nodone", seen, 64'd0);

    // clean window after abort
    set_vec(0, 782, 767, 599790); set_vec(1, 2, 3, 6);
    set_vec(2, 9, 9, 83); set_vec(3, 1, 1, 1);
    run_window("clean");
    check_stats("clean", 4, 2, 6, 4, 782, 767);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
